// File: rtl/score_bcd_formatter.sv
// Binary score to 4-digit BCD via sequential double-dabble (one bit/cycle).
// Ports: clk_i/rst_i, value_i+valid_i/ready_o request, done_o, overflow_o, digit*_o, digit*_en_o.
module score_bcd_formatter #(
  parameter int WIDTH               = 14,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [3:0]       digit0_o,
  output logic [3:0]       digit1_o,
  output logic [3:0]       digit2_o,
  output logic [3:0]       digit3_o,
  output logic             digit0_en_o,
  output logic             digit1_en_o,
  output logic             digit2_en_o,
  output logic             digit3_en_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [3:0]  cnt;
  logic        ovf;

  logic [13:0] value_ext;
  logic        too_big;
  logic        take;
  logic [15:0] bcd_adj;
  logic [3:0]  en_nxt;

  assign value_ext = 14'(value_i);
  assign too_big   = value_ext > 14'd9999;
  assign take      = valid_i && (state == IDLE);

  // add-3 correction on every nibble before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    en_nxt    = 4'b1111;
    if (BLANK_LEADING_ZEROS) begin
      en_nxt[3] = bcd[15:12] != 4'd0;
      en_nxt[2] = en_nxt[3] | (bcd[11:8] != 4'd0);
      en_nxt[1] = en_nxt[2] | (bcd[7:4] != 4'd0);
      en_nxt[0] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd13) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
      digit0_o    <= '0;
      digit1_o    <= '0;
      digit2_o    <= '0;
      digit3_o    <= '0;
      digit0_en_o <= 1'b1;
      digit1_en_o <= !BLANK_LEADING_ZEROS;
      digit2_en_o <= !BLANK_LEADING_ZEROS;
      digit3_en_o <= !BLANK_LEADING_ZEROS;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            bin     <= too_big ? 14'd9999 : value_ext;
            bcd     <= '0;
            cnt     <= '0;
            ovf     <= too_big;
            ready_o <= 1'b0;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
          cnt        <= cnt + 4'd1;
        end
        UPDATE: begin
          digit0_o    <= bcd[3:0];
          digit1_o    <= bcd[7:4];
          digit2_o    <= bcd[11:8];
          digit3_o    <= bcd[15:12];
          digit0_en_o <= en_nxt[0];
          digit1_en_o <= en_nxt[1];
          digit2_en_o <= en_nxt[2];
          digit3_en_o <= en_nxt[3];
          overflow_o  <= ovf;
          done_o      <= 1'b1;
          ready_o     <= 1'b1;
        end
        default: ready_o <= 1'b1;
      endcase
    end
  end

endmodule
